// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control-word pipeline with a halt-drain FSM.
// Optional retired-instruction counter enabled by defining CTRL_PIPE_STATS_EN.
module ctrl_pipe #(
   parameter int CTRL_W = 20,
   parameter int CNT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [CTRL_W-1:0] i_ctrl_word,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_mem_wait,
   input  logic              i_restart,
   output logic              o_ex_reg_dst,
   output logic              o_ex_alu_src,
   output logic              o_ex_shamt_sel,
   output logic              o_ex_link,
   output logic              o_ex_mem_read,
   output logic [3:0]        o_ex_alu_op,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_mem_sign_ext,
   output logic [1:0]        o_mem_width,
   output logic              o_wb_reg_write,
   output logic [1:0]        o_wb_sel,
   output logic              o_draining,
   output logic              o_halted,
   output logic              o_pipe_empty,
   output logic [CNT_W-1:0]  o_retired_cnt
);

   typedef enum logic [1:0] {S_RUN = 2'b00, S_DRAIN = 2'b01, S_HALTED = 2'b10} state_t;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [3:0] alu_op;
      logic       shamt_sel;
      logic       link;
   } ex_t;

   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [1:0] width;
      logic       sext;
   } mem_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] sel;
   } wb_t;

   state_t r_state, w_state_nxt;
   ex_t    w_ex,  r_idex_ex;
   mem_t   w_mem, r_idex_mem, r_exmem_mem;
   wb_t    w_wb,  r_idex_wb,  r_exmem_wb, r_memwb_wb;
   logic   r_idex_v, r_idex_h, r_exmem_v, r_exmem_h, r_memwb_v, r_memwb_h;
   logic   w_load_word, w_kill_halt, w_retire;

   // jump and branch_taken are resolved in ID and never travel down the pipe
   logic   w_unused_bits;
   assign w_unused_bits = &{1'b0, i_ctrl_word[19:18]};

   // split the incoming word into field groups; invalid words become bubbles
   always_comb begin
      w_ex  = '0;
      w_mem = '0;
      w_wb  = '0;
      if (i_ctrl_word[0]) begin
         w_ex  = {i_ctrl_word[17], i_ctrl_word[16], i_ctrl_word[15:12], i_ctrl_word[2], i_ctrl_word[3]};
         w_mem = {i_ctrl_word[11], i_ctrl_word[10], i_ctrl_word[9:8], i_ctrl_word[7]};
         w_wb  = {i_ctrl_word[6], i_ctrl_word[5:4]};
      end else begin
         w_ex  = '0;
         w_mem = '0;
         w_wb  = '0;
      end
   end

   assign w_load_word = !i_mem_wait && !i_flush && !i_stall && (r_state == S_RUN);
   // a flush that catches the halt word still in ID/EX squashes it entirely
   assign w_kill_halt = !i_mem_wait && i_flush && (r_state == S_DRAIN) && r_idex_v && r_idex_h;
   assign w_retire    = !i_mem_wait && r_memwb_v;

   // halt-drain next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (w_load_word && i_ctrl_word[0] && i_ctrl_word[1]) w_state_nxt = S_DRAIN;
            else                                                  w_state_nxt = S_RUN;
         end
         S_DRAIN: begin
            if (w_kill_halt)                  w_state_nxt = S_RUN;
            else if (w_retire && r_memwb_h)   w_state_nxt = S_HALTED;
            else                              w_state_nxt = S_DRAIN;
         end
         S_HALTED: begin
            if (i_restart) w_state_nxt = S_RUN;
            else           w_state_nxt = S_HALTED;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_RUN;
      else          r_state <= w_state_nxt;
   end

   // pipeline stage registers; a global freeze holds every stage
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idex_ex   <= '0;
         r_idex_mem  <= '0;
         r_idex_wb   <= '0;
         r_idex_v    <= 1'b0;
         r_idex_h    <= 1'b0;
         r_exmem_mem <= '0;
         r_exmem_wb  <= '0;
         r_exmem_v   <= 1'b0;
         r_exmem_h   <= 1'b0;
         r_memwb_wb  <= '0;
         r_memwb_v   <= 1'b0;
         r_memwb_h   <= 1'b0;
      end else if (!i_mem_wait) begin
         if (w_load_word) begin
            r_idex_ex  <= w_ex;
            r_idex_mem <= w_mem;
            r_idex_wb  <= w_wb;
            r_idex_v   <= i_ctrl_word[0];
            r_idex_h   <= i_ctrl_word[0] & i_ctrl_word[1];
         end else begin
            r_idex_ex  <= '0;
            r_idex_mem <= '0;
            r_idex_wb  <= '0;
            r_idex_v   <= 1'b0;
            r_idex_h   <= 1'b0;
         end
         if (w_kill_halt) begin
            r_exmem_mem <= '0;
            r_exmem_wb  <= '0;
            r_exmem_v   <= 1'b0;
            r_exmem_h   <= 1'b0;
         end else begin
            r_exmem_mem <= r_idex_mem;
            r_exmem_wb  <= r_idex_wb;
            r_exmem_v   <= r_idex_v;
            r_exmem_h   <= r_idex_h;
         end
         r_memwb_wb <= r_exmem_wb;
         r_memwb_v  <= r_exmem_v;
         r_memwb_h  <= r_exmem_h;
      end
   end

`ifdef CTRL_PIPE_STATS_EN
   logic [CNT_W-1:0] r_retired_cnt;

   // saturating retired-instruction counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_retired_cnt <= {CNT_W{1'b0}};
      else if (w_retire && (r_retired_cnt != {CNT_W{1'b1}}))
         r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign o_retired_cnt = r_retired_cnt;
`else
   assign o_retired_cnt = {CNT_W{1'b0}};
`endif

   assign o_ex_reg_dst   = r_idex_ex.reg_dst;
   assign o_ex_alu_src   = r_idex_ex.alu_src;
   assign o_ex_shamt_sel = r_idex_ex.shamt_sel;
   assign o_ex_link      = r_idex_ex.link;
   assign o_ex_alu_op    = r_idex_ex.alu_op;
   assign o_ex_mem_read  = r_idex_mem.rd;
   assign o_mem_read     = r_exmem_mem.rd;
   assign o_mem_write    = r_exmem_mem.wr;
   assign o_mem_sign_ext = r_exmem_mem.sext;
   assign o_mem_width    = r_exmem_mem.width;
   assign o_wb_reg_write = r_memwb_wb.reg_write;
   assign o_wb_sel       = r_memwb_wb.sel;
   assign o_draining     = (r_state == S_DRAIN);
   assign o_halted       = (r_state == S_HALTED);
   assign o_pipe_empty   = ~(r_idex_v | r_exmem_v | r_memwb_v);

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the ID-stage control word produced by ctrl_register.
- Splits the 20-bit word into EX, MEM and WB field groups.
- Carries each group through the ID/EX, EX/MEM and MEM/WB pipeline registers, honouring stall, flush and freeze.
- Runs a halt-drain FSM and keeps a retired-instruction counter for the debug unit.

Parameters:
- CTRL_W, 20, control word width; fixed layout below.
- CNT_W, 32, retired-counter width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ctrl_word  in  CTRL_W  control word from ID.
  - [19] jump, [18] branch_taken (both consumed in ID, not propagated).
  - [17] reg_dst, [16] alu_src, [15:12] alu_op, [11] mem_read, [10] mem_write.
  - [9:8] mem_width (00 byte / 01 half / 11 word), [7] mem_sign_ext, [6] reg_write.
  - [5:4] wb_sel (00 alu / 01 mem / 10 pc+8), [3] link, [2] shamt_sel, [1] halt, [0] valid.
- i_stall  in  1  load-use stall; ID/EX loads a bubble.
- i_flush  in  1  kill the word entering ID/EX (branch/jump).
- i_mem_wait  in  1  global freeze; all stages hold.
- i_restart  in  1  leave HALTED.
- o_ex_reg_dst, o_ex_alu_src, o_ex_shamt_sel, o_ex_link, o_ex_mem_read  out  1 each  ID/EX fields.
- o_ex_alu_op  out  4  ID/EX field.
- o_mem_read, o_mem_write, o_mem_sign_ext  out  1 each  EX/MEM fields.
- o_mem_width  out  2  EX/MEM field.
- o_wb_reg_write  out  1  MEM/WB field.
- o_wb_sel  out  2  MEM/WB field.
- o_draining  out  1  FSM in DRAIN.
- o_halted  out  1  FSM in HALTED.
- o_pipe_empty  out  1  no valid word in any stage.
- o_retired_cnt  out  CNT_W  retired valid instructions.

Behaviour:
- Reset (async, active-low): all stage registers hold a bubble (all zero); FSM=RUN; o_draining=0, o_halted=0, o_pipe_empty=1, o_retired_cnt=0.
- Each stage stores its field group plus valid and halt bits. Outputs are direct register outputs, so each group appears 1 cycle after acceptance.
- Per-edge priority:
  - i_mem_wait=1: every stage holds; i_stall and i_flush are ignored, and the hazard unit keeps them asserted.
  - else i_flush=1: ID/EX←bubble; EX/MEM←ID/EX; MEM/WB←EX/MEM.
  - else i_stall=1: same advance as flush. ID-side hold is the PC/IF-ID's job.
  - else: ID/EX←i_ctrl_word, or a bubble if FSM≠RUN; downstream stages advance.
- A word with valid=0 is treated as a bubble: all fields are forced to 0 on load.
- Retire event: MEM/WB valid=1 and i_mem_wait=0 at an edge. o_retired_cnt +1 per event, saturates at all-ones, does not wrap.
- FSM:
  - RUN→DRAIN when a valid word with halt=1 is loaded into ID/EX.
  - DRAIN: ID/EX loads bubbles; o_draining=1.
  - DRAIN→RUN if i_flush kills the halt word. This is only possible while the halt word is in ID/EX: flush acts on the entering word, so the halt word is overwritten only if it is still at ID/EX when a flush loads the bubble.
  - DRAIN→HALTED on the retire event of the halt word.
  - HALTED: all stages bubbles; o_halted=1; counter frozen; i_stall, i_flush and i_ctrl_word ignored.
  - HALTED→RUN on i_restart=1. i_restart is ignored in RUN and DRAIN.
  - Simultaneous halt load and i_restart: halt wins.
- o_pipe_empty = NOR of the three stage valid bits (combinational).
- Reset mid-drain returns to RUN with an empty pipe and the counter cleared.

Optional Feature:
- CTRL_PIPE_STATS_EN defined: o_retired_cnt operates as specified.
- Not defined: counter register is removed and o_retired_cnt is tied to 0. All other behaviour is unchanged.

Test Plan:
- LW word 0x12B51 with no stall:
  - cycle+1: o_ex_alu_src=1, o_ex_alu_op=4'h2, o_ex_mem_read=1.
  - cycle+2: o_mem_read=1, o_mem_width=2'b11.
  - cycle+3: o_wb_reg_write=1, o_wb_sel=2'b01.
  - o_retired_cnt=1 one cycle later (STATS_EN).
- i_stall=1 for one cycle with 0x12B51 present: ID/EX shows a bubble (all EX fields 0) that cycle; older words advance; o_retired_cnt still counts only valid words.
- i_mem_wait=1 for 3 cycles mid-stream, with i_flush=1 in one of those cycles: all outputs frozen, no flush effect, counter unchanged.
- Halt word 0x00003:
  - o_draining=1 at cycle+1.
  - Following inputs are ignored.
  - o_halted=1 at cycle+4, counter +1.
  - i_restart pulse returns to RUN; next 0x12B51 propagates normally.
- Halt word followed by i_flush while the halt word is in ID/EX: FSM returns to RUN, o_halted never asserts, counter unchanged.
- Assert i_rst_n=0 while in DRAIN: all outputs 0 immediately (async), o_pipe_empty=1, FSM=RUN after release.
